// File: rtl/dg_dac_pkg.sv
// Shared constants for the DAC sample sequencer slice.
// Level width helper sized so a FIFO can report 0..DEPTH inclusive.
package dg_dac_pkg;

   localparam int DAC_DW = 8;
   localparam int DAC_FIFO_DEPTH = 4;
   localparam logic [7:0] DAC_RESET_CODE = 8'h80;

   function automatic int dac_lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int DAC_LVL_W = dac_lvl_w(DAC_FIFO_DEPTH);

   typedef struct packed {
      logic push;
      logic pop;
   } fifo_op_t;

endpackage

// File: rtl/dg_dac_sample_sequencer_if.sv
// Valid/ready sample write port into the DAC sequencer.
// Master drives words, slave reports FIFO space.
interface dg_dac_sample_sequencer_if
   import dg_dac_pkg::*;
#(
   parameter int DW = DAC_DW
) ();

   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_ready;

   modport master (
      output wr_valid,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      output wr_ready
   );

endinterface

// File: rtl/dg_dac_fifo.sv
// Small synchronous FIFO; a push while full is dropped even if a
// pop happens in the same cycle.
module dg_dac_fifo
   import dg_dac_pkg::*;
#(
   parameter  int DW    = DAC_DW,
   parameter  int DEPTH = DAC_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = dac_lvl_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] rd_data_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   fifo_op_t      op;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign op.push   = push_i & ~full_o;
   assign op.pop    = pop_i & ~empty_o;
   assign rd_data_o = mem_q[rptr_q];
   assign level_o   = level_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (op.push) wptr_d = wptr_q + AW'(1);
      if (op.pop)  rptr_d = rptr_q + AW'(1);
      unique case (op)
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset; the level gates what is visible.
   always_ff @(posedge clk) begin
      if (op.push) mem_q[wptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/dg_dac_sample_sequencer.sv
// Buffers sample words and releases one per divider tick to the
// DAC code bus, flagging ticks that find the buffer empty.
module dg_dac_sample_sequencer
   import dg_dac_pkg::*;
#(
   parameter  int            DW         = DAC_DW,
   parameter  int            DEPTH      = DAC_FIFO_DEPTH,
   parameter  int            DIVW       = 8,
   parameter  logic [DW-1:0] RESET_CODE = DW'(DAC_RESET_CODE),
   localparam int            LW         = dac_lvl_w(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DIVW-1:0]      div,
   dg_dac_sample_sequencer_if.slave wr,
   input  logic                 clr_underrun,
   output logic [DW-1:0]        dac_code,
   output logic                 dac_update,
   output logic [LW-1:0]        fifo_level,
   output logic                 underrun
);

   logic [DIVW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   code_q, code_d;
   logic            upd_q, upd_d;
   logic            unr_q, unr_d;
   logic            tick;
   logic            pop;
   logic            full;
   logic            empty;
   logic [DW-1:0]   head;

   // >= rather than == so a lowered div ticks at once instead of wrapping.
   assign tick = en & (cnt_q >= div);
   assign pop  = tick & ~empty;

   dg_dac_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (wr.wr_valid),
      .wr_data_i (wr.wr_data),
      .pop_i     (pop),
      .rd_data_o (head),
      .level_o   (fifo_level),
      .full_o    (full),
      .empty_o   (empty)
   );

   assign wr.wr_ready = ~full;

   always_comb begin
      cnt_d  = cnt_q + DIVW'(1);
      if (!en || tick) cnt_d = '0;
      code_d = pop ? head : code_q;
      upd_d  = pop;
      // A fresh underrun beats a simultaneous clear.
      unr_d  = (tick & empty) | (unr_q & ~clr_underrun);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         code_q <= RESET_CODE;
         upd_q  <= 1'b0;
         unr_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         code_q <= code_d;
         upd_q  <= upd_d;
         unr_q  <= unr_d;
      end
   end

   assign dac_code   = code_q;
   assign dac_update = upd_q;
   assign underrun   = unr_q;

endmodule
